voice_sequencer: RTL and testbench

VOICE_SEQUENCER -- requirements
Module: voice_sequencer

---
 rtl/voice_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_voice_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_sequencer.sv
// voice_sequencer: time-multiplexed phase-accumulator voice sequencer.
//
// Each sample_tick starts one mixing frame. Every voice in turn is stepped:
// its phase advances by its increment, one external generator request is
// issued, and the returned sample is summed into an accumulator. At the end
// of the frame the accumulated value is reduced to a BITDEPTH-bit mix.
//
// Compile-time option:
//   VOICE_SEQUENCER_SAT_EN  defined   -> mix_out = min(acc, 2^BITDEPTH-1)
//                           undefined -> mix_out = acc >> log2(NVOICES)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   sample_tick           one-clk strobe starting a frame
//   cfg_we, cfg_voice     per-voice config write strobe and target voice
//   cfg_increment         16-bit phase step
//   cfg_wave              4-bit waveform select
//   cfg_enable            voice on
//   cfg_phase_clr         zero the target voice's phase (with cfg_we)
//   gen_req               one-clk generator request
//   gen_phase, gen_wave   integer phase and waveform for the generator
//   gen_sample            generator result, sampled one clk after gen_req
//   mix_out, mix_valid    mixed sample and its one-clk strobe
//   busy                  frame in progress
//   overrun, overrun_clr  sticky lost-tick flag and its clear
module voice_sequencer #(
    parameter int NVOICES     = 4,
    parameter int BITDEPTH    = 12,
    parameter int BITFRACTION = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_tick,
    input  logic                       cfg_we,
    input  logic [$clog2(NVOICES)-1:0] cfg_voice,
    input  logic [15:0]                cfg_increment,
    input  logic [3:0]                 cfg_wave,
    input  logic                       cfg_enable,
    input  logic                       cfg_phase_clr,
    output logic                       gen_req,
    output logic [BITDEPTH-1:0]        gen_phase,
    output logic [3:0]                 gen_wave,
    input  logic [BITDEPTH-1:0]        gen_sample,
    output logic [BITDEPTH-1:0]        mix_out,
    output logic                       mix_valid,
    output logic                       busy,
    output logic                       overrun,
    input  logic                       overrun_clr
);

    localparam int PW   = BITDEPTH + BITFRACTION;
    localparam int VW   = $clog2(NVOICES);
    localparam int ACCW = BITDEPTH + VW;

    typedef enum logic [1:0] {IDLE, STEP, WAIT, DONE} state_t;

    state_t              state, state_next;
    logic [VW-1:0]       v;
    logic [ACCW-1:0]     acc;
    logic                en_latched;

    logic [PW-1:0]       phase     [NVOICES];
    logic [15:0]         increment [NVOICES];
    logic [3:0]          wave      [NVOICES];
    logic                enable    [NVOICES];

    logic                start, do_step, do_acc, do_done, lost_tick, last_voice;
    logic [PW-1:0]       phase_stepped;
    logic [BITDEPTH-1:0] mix_value;

    always_comb begin
        phase_stepped = phase[v] + PW'(increment[v]);
        last_voice    = (v == VW'(NVOICES - 1));
    end

    always_comb begin
`ifdef VOICE_SEQUENCER_SAT_EN
        mix_value = (acc > ACCW'({BITDEPTH{1'b1}})) ? '1 : acc[BITDEPTH-1:0];
`else
        mix_value = acc[ACCW-1:VW];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        do_step    = 1'b0;
        do_acc     = 1'b0;
        do_done    = 1'b0;
        busy       = (state != IDLE);
        lost_tick  = sample_tick && (state != IDLE);
        case (state)
            IDLE: if (sample_tick) begin
                start      = 1'b1;
                state_next = STEP;
            end
            STEP: begin
                do_step    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                do_acc     = 1'b1;
                state_next = last_voice ? DONE : STEP;
            end
            DONE: begin
                do_done    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Config writes are placed after the step update so a same-clk
    // cfg_phase_clr overrides the phase advance; the step itself reads the
    // pre-edge register values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NVOICES; i++) begin
                phase[i]     <= '0;
                increment[i] <= '0;
                wave[i]      <= '0;
                enable[i]    <= 1'b0;
            end
        end else begin
            if (do_step && enable[v]) phase[v] <= phase_stepped;
            if (cfg_we) begin
                increment[cfg_voice] <= cfg_increment;
                wave[cfg_voice]      <= cfg_wave;
                enable[cfg_voice]    <= cfg_enable;
                if (cfg_phase_clr) phase[cfg_voice] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v          <= '0;
            acc        <= '0;
            en_latched <= 1'b0;
            gen_req    <= 1'b0;
            gen_phase  <= '0;
            gen_wave   <= '0;
            mix_out    <= '0;
            mix_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            gen_req   <= 1'b0;
            mix_valid <= 1'b0;
            if (start) begin
                v   <= '0;
                acc <= '0;
            end
            if (do_step) begin
                // The enable seen here decides the WAIT contribution, even if
                // the voice is reconfigured in between.
                en_latched <= enable[v];
                if (enable[v]) begin
                    gen_req   <= 1'b1;
                    gen_phase <= phase_stepped[PW-1:BITFRACTION];
                    gen_wave  <= wave[v];
                end
            end
            if (do_acc) begin
                if (en_latched) acc <= acc + ACCW'(gen_sample);
                if (!last_voice) v <= v + VW'(1);
            end
            if (do_done) begin
                mix_out   <= mix_value;
                mix_valid <= 1'b1;
            end
            if (lost_tick)        overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_voice_sequencer.sv
// tb_voice_sequencer: randomized self-checking bench for voice_sequencer
// (NVOICES=4, BITDEPTH=12, BITFRACTION=12) against a frame-level model.
// The generator stub derives its sample from gen_phase/gen_wave, or returns
// a fixed value when stub_const is set.
module tb_voice_sequencer;

    localparam int NV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_voice = '0;
    logic [15:0] cfg_increment = '0;
    logic [3:0]  cfg_wave = '0;
    logic        cfg_enable = 1'b0;
    logic        cfg_phase_clr = 1'b0;
    logic        overrun_clr = 1'b0;
    logic        gen_req;
    logic [11:0] gen_phase;
    logic [3:0]  gen_wave;
    logic [11:0] gen_sample;
    logic [11:0] mix_out;
    logic        mix_valid;
    logic        busy;
    logic        overrun;

    voice_sequencer #(.NVOICES(4), .BITDEPTH(12), .BITFRACTION(12)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
        .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_increment(cfg_increment),
        .cfg_wave(cfg_wave), .cfg_enable(cfg_enable), .cfg_phase_clr(cfg_phase_clr),
        .gen_req(gen_req), .gen_phase(gen_phase), .gen_wave(gen_wave),
        .gen_sample(gen_sample), .mix_out(mix_out), .mix_valid(mix_valid),
        .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    bit          stub_const = 1'b0;
    logic [11:0] stub_val = '0;

    function automatic logic [11:0] stub_fn(input logic [11:0] p, input logic [3:0] w);
        return 12'(p * 12'd5 + {w, w, w});
    endfunction

    assign gen_sample = stub_const ? stub_val : stub_fn(gen_phase, gen_wave);

    // Reference model state
    int unsigned m_phase [NV];
    int unsigned m_inc   [NV];
    int unsigned m_wave  [NV];
    bit          m_en    [NV];
    int unsigned m_gphase, m_gwave;
    bit          m_ovr;

    // Per-frame hooks (edge index counted from the tick edge = 0)
    int          race_at = -1, race_v = 0, race_inc = 0, race_w = 0;
    bit          race_en = 1'b0, race_clr = 1'b0;
    int          tick_at = -1, clr_at = -1;
    logic [11:0] seen_mix;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step_clk;
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset;
        for (int i = 0; i < NV; i++) begin
            m_phase[i] = 0; m_inc[i] = 0; m_wave[i] = 0; m_en[i] = 1'b0;
        end
        m_gphase = 0; m_gwave = 0; m_ovr = 1'b0;
    endfunction

    function automatic void model_cfg(input int v, input int inc, input int w,
                                      input bit en, input bit clr);
        m_inc[v]  = inc & 32'hFFFF;
        m_wave[v] = w & 32'hF;
        m_en[v]   = en;
        if (clr) m_phase[v] = 0;
    endfunction

    task automatic cfg_write(input int v, input int inc, input int w, input bit en, input bit clr);
        cfg_voice = 2'(v); cfg_increment = 16'(inc); cfg_wave = 4'(w);
        cfg_enable = en; cfg_phase_clr = clr; cfg_we = 1'b1;
        step_clk;
        cfg_we = 1'b0; cfg_phase_clr = 1'b0;
        model_cfg(v, inc, w, en, clr);
    endtask

    task automatic run_frame;
        int exp_acc, exp_mix, exp_pulses, pulses, valids, valid_k;
        exp_acc = 0; exp_pulses = 0; pulses = 0; valids = 0; valid_k = -1;
        sample_tick = 1'b1;
        step_clk;
        sample_tick = 1'b0;
        check_eq("busy_start", busy, 1);
        for (int k = 1; k <= 12; k++) begin
            if (k == race_at) begin
                cfg_voice = 2'(race_v); cfg_increment = 16'(race_inc); cfg_wave = 4'(race_w);
                cfg_enable = race_en; cfg_phase_clr = race_clr; cfg_we = 1'b1;
            end
            if (k == tick_at) sample_tick = 1'b1;
            if (k == clr_at)  overrun_clr = 1'b1;
            step_clk;
            cfg_we = 1'b0; cfg_phase_clr = 1'b0; sample_tick = 1'b0; overrun_clr = 1'b0;
            if (gen_req) pulses++;
            if (mix_valid) begin
                valids++; valid_k = k; seen_mix = mix_out;
            end
            if ((k % 2 == 1) && (k <= 2 * NV)) begin
                int vi;
                vi = (k - 1) / 2;
                if (m_en[vi]) begin
                    m_phase[vi] = (m_phase[vi] + m_inc[vi]) & 32'hFFFFFF;
                    m_gphase = m_phase[vi] >> 12;
                    m_gwave  = m_wave[vi];
                    exp_pulses++;
                    exp_acc += stub_const ? int'(stub_val)
                                          : int'(stub_fn(12'(m_gphase), 4'(m_gwave)));
                end
                check_eq($sformatf("gen_req_v%0d", vi), gen_req, 32'(m_en[vi]));
                check_eq($sformatf("gen_phase_v%0d", vi), gen_phase, m_gphase);
                check_eq($sformatf("gen_wave_v%0d", vi), gen_wave, m_gwave);
            end
            if (k == race_at) model_cfg(race_v, race_inc, race_w, race_en, race_clr);
            if (k == tick_at)     m_ovr = 1'b1;
            else if (k == clr_at) m_ovr = 1'b0;
        end
`ifdef VOICE_SEQUENCER_SAT_EN
        exp_mix = (exp_acc > 4095) ? 4095 : exp_acc;
`else
        exp_mix = exp_acc >> 2;
`endif
        check_eq("mix_valid_count", valids, 1);
        check_eq("mix_latency", valid_k, 2 * NV + 1);
        check_eq("mix_out", seen_mix, exp_mix);
        check_eq("gen_req_pulses", pulses, exp_pulses);
        check_eq("overrun", overrun, 32'(m_ovr));
        check_eq("busy_end", busy, 0);
        race_at = -1; tick_at = -1; clr_at = -1;
    endtask

    initial begin
        int nvalid;
        model_reset();
        repeat (2) step_clk;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mix_out", mix_out, 0);
        check_eq("rst_mix_valid", mix_valid, 0);
        check_eq("rst_gen_req", gen_req, 0);
        check_eq("rst_overrun", overrun, 0);
        #3 rst_n = 1'b1;
        step_clk;

        // Single voice stepping
        cfg_write(0, 16'h1000, 3, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            run_frame();
            check_eq("single_phase", gen_phase, i);
        end

        // Mix rule with a constant generator
        stub_const = 1'b1; stub_val = 12'h800;
        for (int i = 0; i < NV; i++) cfg_write(i, 16'h0100, i, 1'b1, 1'b0);
        run_frame();
`ifdef VOICE_SEQUENCER_SAT_EN
        check_eq("mix4_const", seen_mix, 12'hFFF);
`else
        check_eq("mix4_const", seen_mix, 12'h800);
`endif
        cfg_write(2, 0, 0, 1'b0, 1'b0);
        cfg_write(3, 0, 0, 1'b0, 1'b0);
        run_frame();
`ifdef VOICE_SEQUENCER_SAT_EN
        check_eq("mix2_const", seen_mix, 12'hFFF);
`else
        check_eq("mix2_const", seen_mix, 12'h400);
`endif
        stub_const = 1'b0;

        // Phase wrap: 256 steps of 0xFFFF reach 0xFFFF00
        cfg_write(1, 0, 0, 1'b0, 1'b0);
        cfg_write(0, 16'hFFFF, 2, 1'b1, 1'b1);
        for (int i = 0; i < 256; i++) run_frame();
        check_eq("wrap_pre", gen_phase, 12'hFFF);
        cfg_write(0, 16'h0100, 2, 1'b1, 1'b0);
        run_frame();
        check_eq("wrap_gen_phase", gen_phase, 0);
        check_eq("wrap_model", m_phase[0], 0);

        // Config race on voice1's STEP clk; voice2 disabled contributes 0
        cfg_write(1, 16'h1000, 1, 1'b1, 1'b1);
        cfg_write(2, 16'h0400, 6, 1'b0, 1'b0);
        cfg_write(3, 16'h0123, 7, 1'b0, 1'b0);
        race_at = 3; race_v = 1; race_inc = 16'h2000; race_w = 5; race_en = 1'b1; race_clr = 1'b0;
        run_frame();
        check_eq("race_old_inc", gen_phase, 1);
        run_frame();
        check_eq("race_new_inc", gen_phase, 3);
        race_at = 3; race_v = 1; race_inc = 16'h2000; race_w = 5; race_en = 1'b1; race_clr = 1'b1;
        run_frame();
        run_frame();
        check_eq("race_clr_wins", gen_phase, 2);
        cfg_write(3, 16'h0123, 7, 1'b1, 1'b0);
        race_at = 4; race_v = 1; race_inc = 16'h0300; race_w = 9; race_en = 1'b0; race_clr = 1'b0;
        run_frame();
        run_frame();

        // Overrun
        tick_at = 3;
        run_frame();
        check_eq("overrun_set", overrun, 1);
        overrun_clr = 1'b1;
        step_clk;
        overrun_clr = 1'b0; m_ovr = 1'b0;
        check_eq("overrun_clr", overrun, 0);
        tick_at = 9;
        run_frame();
        overrun_clr = 1'b1;
        step_clk;
        overrun_clr = 1'b0; m_ovr = 1'b0;
        tick_at = 5; clr_at = 5;
        run_frame();
        check_eq("overrun_set_wins", overrun, 1);

        // Reset during STEP for voice 2
        cfg_write(0, 16'h1000, 4, 1'b1, 1'b0);
        cfg_write(1, 16'h1000, 4, 1'b1, 1'b0);
        sample_tick = 1'b1;
        step_clk;
        sample_tick = 1'b0;
        repeat (4) step_clk;
        check_eq("midframe_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_gen_req", gen_req, 0);
        check_eq("arst_gen_phase", gen_phase, 0);
        check_eq("arst_gen_wave", gen_wave, 0);
        check_eq("arst_mix_out", mix_out, 0);
        check_eq("arst_mix_valid", mix_valid, 0);
        check_eq("arst_overrun", overrun, 0);
        model_reset();
        step_clk;
        #2 rst_n = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            step_clk;
            if (mix_valid) nvalid++;
        end
        check_eq("no_valid_after_reset", nvalid, 0);
        run_frame();

        // Randomized frames
        for (int it = 0; it < 40; it++) begin
            int nw;
            nw = $urandom_range(0, 2);
            for (int j = 0; j < nw; j++)
                cfg_write($urandom_range(0, NV - 1), $urandom_range(0, 16'hFFFF),
                          $urandom_range(0, 15), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 7) == 0));
            stub_const = 1'($urandom_range(0, 3) == 0);
            stub_val   = 12'($urandom_range(0, 12'hFFF));
            if ($urandom_range(0, 1) == 1) begin
                race_at  = $urandom_range(1, 9);
                race_v   = $urandom_range(0, NV - 1);
                race_inc = $urandom_range(0, 16'hFFFF);
                race_w   = $urandom_range(0, 15);
                race_en  = 1'($urandom_range(0, 1));
                race_clr = 1'($urandom_range(0, 1));
            end
            run_frame();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
